adc_buffer_writer: RTL and testbench
====================================

ADC_BUFFER_WRITER -- requirements
Module: adc_buffer_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, RAM word width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 12, RAM address width.
REQ-003 SHALL have parameter SAMPLE_WIDTH, default 12, ADC sample width; legal range 1..16.
REQ-004 SHALL have parameter BASE_ADDR, default 12'h800, first RAM word of the capture buffer.
REQ-005 SHALL have parameter BUF_LEN, default 1024, buffer length in words; even, at least 2; BASE_ADDR+BUF_LEN fits the address space.
REQ-006 SHALL have port clk, input, 1 bit, single clock, rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1 bit, one-cycle pulse that begins capture.
REQ-009 SHALL have port stop, input, 1 bit, one-cycle pulse that ends capture.
REQ-010 SHALL have port one_shot, input, 1 bit, sampled at start: 1 = fill once, 0 = ring.
REQ-011 SHALL have port sample_valid, input, 1 bit, ADC sample present.
REQ-012 SHALL have port sample_data, input, SAMPLE_WIDTH bits, ADC sample.
REQ-013 SHALL have port sample_ready, output, 1 bit, sample accepted when valid&&ready.
REQ-014 SHALL have port adc_wEn, output, 1 bit, RAM port-B write enable.
REQ-015 SHALL have port adc_addr, output, ADDRESS_WIDTH bits, RAM port-B address.
REQ-016 SHALL have port adc_dataIn, output, DATA_WIDTH bits, RAM port-B write data.
REQ-017 SHALL have port wr_ptr, output, ADDRESS_WIDTH bits, offset of the next word to write.
REQ-018 SHALL have ports busy, done, half_irq, full_irq and overrun, outputs, 1 bit each, status flags.
REQ-019 SHALL have port irq_clr, input, 1 bit, pulse that clears half_irq, full_irq and overrun.

Function
REQ-020 SHALL implement states IDLE, CAPTURE and DONE; busy=1 only in CAPTURE; done=1 only in DONE.
REQ-021 SHALL move IDLE/DONE->CAPTURE on start, clearing wr_ptr to 0 and latching one_shot.
REQ-022 SHALL ignore start while in CAPTURE.
REQ-023 SHALL drive sample_ready=1 exactly when in CAPTURE.
REQ-024 SHALL accept a sample in the cycle it is offered, regardless of whether adc_wEn is asserted that cycle.
REQ-025 SHALL, for each word completed, assert adc_wEn for one cycle on the next cycle, with adc_addr=BASE_ADDR+wr_ptr and sample data zero-extended in adc_dataIn.
REQ-026 SHALL sustain one word per cycle with no bubbles.
REQ-027 SHALL increment wr_ptr by 1 per word written and wrap it from BUF_LEN-1 to 0.
REQ-028 SHALL hold adc_wEn=0 in all other cycles; adc_addr and adc_dataIn hold their last values.
REQ-029 SHALL set half_irq when word BUF_LEN/2-1 is written.
REQ-030 SHALL set full_irq when word BUF_LEN-1 is written.
REQ-031 SHALL set overrun when full_irq is set while full_irq is already 1 (ring mode, CPU too slow).
REQ-032 SHALL, in one-shot mode, move to DONE after word BUF_LEN-1 is written, with sample_ready low from the cycle that word's last sample is accepted.
REQ-033 SHALL move CAPTURE->IDLE on stop; a sample accepted in the same cycle is still written.
REQ-034 SHALL let stop win over start when both occur in the same cycle.
REQ-035 SHALL let a set win over irq_clr when both occur in the same cycle.

Reset
REQ-036 SHALL, when reset_n=0, asynchronously force state IDLE and all outputs 0 (sample_ready, adc_wEn, adc_addr, adc_dataIn, wr_ptr, busy, done, all irq flags).
REQ-037 SHALL drop any in-flight write on reset mid-capture; no adc_wEn pulse after reset release until a new start.

Configuration
REQ-038 SHALL, with macro ADC_PACK_EN defined, pack two samples per word: first in [15:0], second in [31:16], each zero-extended to 16 bits, written after the second sample; on stop with a half word pending, flush it with [31:16]=0.
REQ-039 SHALL, with ADC_PACK_EN undefined, write one sample per word.

Verification
REQ-040 SHALL test: BUF_LEN=8, one_shot=1, start, 8 samples 1..8 back-to-back -> adc_wEn on 8 consecutive cycles, addr 0x800..0x807, data 1..8, half_irq at word 3, full_irq at word 7, done=1, sample_ready=0.
REQ-041 SHALL test: ring mode, 10 samples, no irq_clr -> wr_ptr wraps, 9th word at 0x800, overrun=0; 18 samples without clear -> overrun=1.
REQ-042 SHALL test: stop and sample_valid in the same cycle -> that sample written, then IDLE; start+stop together in IDLE -> stays IDLE.
REQ-043 SHALL test: reset_n low one cycle after an accepted sample -> no adc_wEn, all outputs 0.
REQ-044 SHALL test: ADC_PACK_EN, samples 0xABC, 0x123 -> one write, data 0x01230ABC; 3 samples then stop -> second word 0x00000xyz.
REQ-045 SHALL test: irq_clr coincident with half_irq set -> half_irq=1.

Source files
------------

// File: rtl/adc_buffer_writer.sv
// adc_buffer_writer: streams ADC samples into a RAM ring/one-shot buffer with half/full/overrun flags.
// Define ADC_PACK_EN to pack two 16-bit zero-extended samples per RAM word.
module adc_buffer_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int SAMPLE_WIDTH = 12,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = 'h800,
  parameter int BUF_LEN = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     one_shot,
  input  logic                     sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]  sample_data,
  output logic                     sample_ready,
  output logic                     adc_wEn,
  output logic [ADDRESS_WIDTH-1:0] adc_addr,
  output logic [DATA_WIDTH-1:0]    adc_dataIn,
  output logic [ADDRESS_WIDTH-1:0] wr_ptr,
  output logic                     busy,
  output logic                     done,
  output logic                     half_irq,
  output logic                     full_irq,
  output logic                     overrun,
  input  logic                     irq_clr
);
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(BUF_LEN - 1);
  localparam logic [ADDRESS_WIDTH-1:0] MID = ADDRESS_WIDTH'(BUF_LEN / 2 - 1);
  state_t                   r_state;
  logic                     r_one_shot, r_busy, r_done, r_wen, r_half, r_full, r_ovr;
  logic [ADDRESS_WIDTH-1:0] r_ptr, r_addr;
  logic [DATA_WIDTH-1:0]    r_data;
  logic                     w_acc, w_word, w_mid, w_last;
  logic [DATA_WIDTH-1:0]    w_wdata;
  logic [ADDRESS_WIDTH-1:0] w_ptr_nxt;
  assign w_acc = sample_valid & r_busy;
  assign w_mid = r_ptr == MID;
  assign w_last = r_ptr == LAST;
  assign w_ptr_nxt = w_last ? '0 : r_ptr + ADDRESS_WIDTH'(1);
`ifdef ADC_PACK_EN
  logic        r_pend;
  logic [15:0] r_lo;
  logic        w_stop;
  logic [15:0] w_samp;
  assign w_stop = stop & r_busy;
  assign w_samp = 16'(sample_data);
  // a stop flushes whatever half word exists, including one started this very cycle
  assign w_word = (w_acc & r_pend) | (w_stop & (r_pend | w_acc));
  assign w_wdata = DATA_WIDTH'(w_acc & r_pend ? {w_samp, r_lo} : {16'h0, w_acc ? w_samp : r_lo});
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= 1'b0;
      r_lo <= '0;
    end else begin
      r_pend <= w_stop ? 1'b0 : (w_acc ? ~r_pend : r_pend);
      if (w_acc & ~r_pend) r_lo <= w_samp;
    end
  end
`else
  assign w_word = w_acc;
  assign w_wdata = DATA_WIDTH'(sample_data);
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_one_shot <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_wen <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_ptr <= '0;
      r_half <= 1'b0;
      r_full <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      r_wen <= w_word;
      if (w_word) begin
        r_addr <= BASE_ADDR + r_ptr;
        r_data <= w_wdata;
        r_ptr <= w_ptr_nxt;
      end
      r_half <= (w_word & w_mid) | (r_half & ~irq_clr);
      r_full <= (w_word & w_last) | (r_full & ~irq_clr);
      r_ovr <= (w_word & w_last & r_full) | (r_ovr & ~irq_clr);
      if (r_state == CAPTURE) begin
        if (stop) begin
          r_state <= IDLE;
          r_busy <= 1'b0;
        end else if (w_word & w_last & r_one_shot) begin
          r_state <= DONE;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (start & ~stop) begin
        r_state <= CAPTURE;
        r_busy <= 1'b1;
        r_done <= 1'b0;
        r_ptr <= '0;
        r_one_shot <= one_shot;
      end
    end
  end
  assign sample_ready = r_busy;
  assign busy = r_busy;
  assign done = r_done;
  assign adc_wEn = r_wen;
  assign adc_addr = r_addr;
  assign adc_dataIn = r_data;
  assign wr_ptr = r_ptr;
  assign half_irq = r_half;
  assign full_irq = r_full;
  assign overrun = r_ovr;
endmodule

// File: tb/tb_adc_buffer_writer.sv
// tb_adc_buffer_writer: randomized and directed stimulus checked against a word-count reference model.
module tb_adc_buffer_writer;
  localparam int BL = 8;
  localparam int BASE = 'h800;
`ifdef ADC_PACK_EN
  localparam int SPW = 2;
`else
  localparam int SPW = 1;
`endif
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, one_shot = 1'b0, sample_valid = 1'b0, irq_clr = 1'b0;
  logic [11:0] sample_data = '0;
  logic        sample_ready, adc_wEn, busy, done, half_irq, full_irq, overrun;
  logic [11:0] adc_addr, wr_ptr;
  logic [31:0] adc_dataIn;
  int n_chk = 0, n_pass = 0;
  bit m_cap, m_fin, m_os, m_pend, e_wen, e_half, e_full, e_ovr;
  int m_words, m_lo, e_addr, e_data;
  adc_buffer_writer #(.BUF_LEN(BL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .one_shot(one_shot),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
    .adc_wEn(adc_wEn), .adc_addr(adc_addr), .adc_dataIn(adc_dataIn), .wr_ptr(wr_ptr),
    .busy(busy), .done(done), .half_irq(half_irq), .full_irq(full_irq), .overrun(overrun),
    .irq_clr(irq_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask
  task automatic check_all();
    chk("ready", 32'(sample_ready), 32'(m_cap));
    chk("busy", 32'(busy), 32'(m_cap));
    chk("done", 32'(done), 32'(m_fin));
    chk("wen", 32'(adc_wEn), 32'(e_wen));
    chk("addr", 32'(adc_addr), e_addr);
    chk("data", adc_dataIn, e_data);
    chk("wr_ptr", 32'(wr_ptr), m_words % BL);
    chk("half_irq", 32'(half_irq), 32'(e_half));
    chk("full_irq", 32'(full_irq), 32'(e_full));
    chk("overrun", 32'(overrun), 32'(e_ovr));
  endtask
  task automatic mreset();
    {m_cap, m_fin, m_os, m_pend, e_wen, e_half, e_full, e_ovr} = '0;
    m_words = 0; m_lo = 0; e_addr = 0; e_data = 0;
  endtask
  task automatic cyc(input bit st, input bit sp, input bit os, input bit v, input int d, input bit clr);
    bit acc, word, hs, fs, os_set;
    int wd, idx;
    d = d & 'hFFF;
    start = st; stop = sp; one_shot = os; sample_valid = v; sample_data = d[11:0]; irq_clr = clr;
    @(posedge clk);
    acc = m_cap && v; word = 0; wd = 0; idx = m_words % BL;
`ifdef ADC_PACK_EN
    if (acc && m_pend) begin word = 1; wd = (d << 16) | m_lo; m_pend = 0; end
    else if (acc) begin m_pend = 1; m_lo = d; end
    if (m_cap && sp && m_pend) begin word = 1; wd = m_lo; m_pend = 0; end
`else
    if (acc) begin word = 1; wd = d; end
`endif
    hs = word && idx == BL / 2 - 1;
    fs = word && idx == BL - 1;
    os_set = fs && e_full;
    e_half = hs || (e_half && !clr);
    e_full = fs || (e_full && !clr);
    e_ovr = os_set || (e_ovr && !clr);
    e_wen = word;
    if (word) begin e_addr = BASE + idx; e_data = wd; m_words++; end
    if (m_cap) begin
      if (sp) m_cap = 0;
      else if (fs && m_os) begin m_cap = 0; m_fin = 1; end
    end else if (st && !sp) begin
      m_cap = 1; m_fin = 0; m_words = 0; m_os = os;
    end
    #1;
    check_all();
  endtask
  initial begin
    mreset();
    #1;
    check_all();
    #19 reset_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    // one-shot fill of 1..8
    cyc(1, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) cyc(0, 0, 0, 1, i, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 99, 0);
`ifndef ADC_PACK_EN
    chk("oneshot_done", 32'(done), 1);
    chk("oneshot_ready", 32'(sample_ready), 0);
`endif
    // ring mode, 18 samples without clearing
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 18 * SPW; i++) cyc(0, 0, 0, 1, $urandom, 0);
    cyc(0, 1, 0, 0, 0, 0);
    // stop with a sample in the same cycle, then start+stop from IDLE
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 'h5A5, 0);
    cyc(0, 1, 0, 1, 'h3C3, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 'h111, 0);
    // irq_clr coincident with the half-buffer word
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4 * SPW; i++) cyc(0, 0, 0, 1, i + 1, i == 4 * SPW - 1);
    chk("half_vs_clr", 32'(half_irq), 1);
    cyc(0, 1, 0, 0, 0, 0);
    // packing pair then odd sample flushed by stop
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 'hABC, 0);
    cyc(0, 0, 0, 1, 'h123, 0);
    cyc(0, 0, 0, 1, 'h456, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // reset just after an accepted sample
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 'h777, 0);
    reset_n = 1'b0;
    mreset();
    #1;
    check_all();
    #3 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 'h222, 0);
    for (int i = 0; i < 1500; i++)
      cyc($urandom % 20 == 0, $urandom % 40 == 0, $urandom % 2 == 0, $urandom % 4 != 0, $urandom, $urandom % 15 == 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
